// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit core: fetch, decode, execute and
// memory handshake sequencing, with a bounded wait on mem_ready.
module control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_sys_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] ir_1_i,
  input  logic       cc_i,
  input  logic       mem_ready_i,
  output logic       ldMAR_o,
  output logic       ldIR_o,
  output logic       ldFlag_o,
  output logic       ldPC_o,
  output logic       incPC_o,
  output logic       ldMDR_o,
  output logic       ldReg_o,
  output logic       Tlabel_o,
  output logic       ALUon_o,
  output logic [2:0] fnSelect_o,
  output logic       mm_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       halted_o,
  output logic       bus_err_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // F0     | load MAR with PC
  // F1     | instruction read, wait for mem_ready
  // F2     | load IR, increment PC
  // DEC    | dispatch on opcode
  // ALU    | register ALU op, write back result and flags
  // BR     | branch, load PC when cc is true
  // MA_LD  | load: address to MAR
  // LW     | load: memory read, wait for mem_ready
  // WB     | load: write MDR to register file
  // MA_ST  | store: address to MAR
  // SD     | store: capture data bus into MDR
  // SW     | store: memory write, wait for mem_ready
  // CMP    | compare, flags only
  // HALT   | stopped until reset
  // ERR    | memory timeout, stopped until reset
  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_ALU, S_BR, S_MA_LD,
    S_LW, S_WB, S_MA_ST, S_SD, S_SW, S_CMP, S_HALT, S_ERR
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_ir;
    logic       ld_flag;
    logic       inc_pc;
    logic       ld_mdr;
    logic       ld_reg;
    logic       tlabel;
    logic       alu_on;
    logic [2:0] fn_sel;
    logic       mm;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       bus_err;
    logic       br;
    logic       lw;
  } out_t;

  // Last count value before the next low mem_ready cycle trips the timeout.
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  out_t       out_q;

  function automatic out_t decode(input state_t s);
    out_t o;
    o = '0;
    case (s)
      S_F0:    o.ld_mar = 1'b1;
      S_F1:    o.mem_rd = 1'b1;
      S_F2:    begin o.ld_ir = 1'b1; o.inc_pc = 1'b1; end
      S_ALU:   begin o.alu_on = 1'b1; o.ld_reg = 1'b1; o.ld_flag = 1'b1; end
      S_BR:    begin o.tlabel = 1'b1; o.br = 1'b1; end
      S_MA_LD: o.ld_mar = 1'b1;
      S_LW:    begin o.mem_rd = 1'b1; o.lw = 1'b1; end
      S_WB:    o.ld_reg = 1'b1;
      S_MA_ST: o.ld_mar = 1'b1;
      S_SD:    begin o.mm = 1'b1; o.ld_mdr = 1'b1; end
      S_SW:    o.mem_wr = 1'b1;
      S_CMP:   begin o.fn_sel = 3'b001; o.ld_flag = 1'b1; end
      S_HALT:  o.halted = 1'b1;
      S_ERR:   begin o.halted = 1'b1; o.bus_err = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Next-state and wait-counter logic; the counter is zero outside wait states
  // so every wait state is entered with a cleared count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1, S_LW, S_SW: begin
        if (mem_ready_i) begin
          case (state_q)
            S_F1:    state_d = S_F2;
            S_LW:    state_d = S_WB;
            default: state_d = S_F0;
          endcase
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_F2:    state_d = S_DEC;
      S_DEC: begin
        case (ir_1_i)
          4'h0:                   state_d = S_ALU;
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8,
          4'h9:                   state_d = S_BR;
          4'hA:                   state_d = S_MA_LD;
          4'hB:                   state_d = S_MA_ST;
          4'hC:                   state_d = S_CMP;
          4'hF:                   state_d = S_HALT;
          default:                state_d = S_F0;
        endcase
      end
      S_ALU, S_BR, S_CMP, S_WB: state_d = S_F0;
      S_MA_LD: state_d = S_LW;
      S_MA_ST: state_d = S_SD;
      S_SD:    state_d = S_SW;
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered output decode of the upcoming state.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= decode(state_d);
    end
  end

  // ldPC and the LW ldMDR pulse are qualified by live inputs within the state.
  assign ldMAR_o    = out_q.ld_mar;
  assign ldIR_o     = out_q.ld_ir;
  assign ldFlag_o   = out_q.ld_flag;
  assign ldPC_o     = out_q.br & cc_i;
  assign incPC_o    = out_q.inc_pc;
  assign ldMDR_o    = out_q.ld_mdr | (out_q.lw & mem_ready_i);
  assign ldReg_o    = out_q.ld_reg;
  assign Tlabel_o   = out_q.tlabel;
  assign ALUon_o    = out_q.alu_on;
  assign fnSelect_o = out_q.fn_sel;
  assign mm_o       = out_q.mm;
  assign mem_rd_o   = out_q.mem_rd;
  assign mem_wr_o   = out_q.mem_wr;
  assign halted_o   = out_q.halted;
  assign bus_err_o  = out_q.bus_err;

endmodule
